// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared constants, bus FSM states and code conversion for apb_dac
package dac_pkg;

  localparam int DEF_RES_BITS      = 14;
  localparam int DEF_SETTLE_CYCLES = 4;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_CTRL   = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } apb_st_e;

  // Full scale is 2**bits, so the largest code lands just below 1.0.
  function automatic real code2real(input logic [31:0] code, input int bits);
    return real'(code) / real'(64'd1 << bits);
  endfunction

endpackage

// File: rtl/apb_wait_fsm.sv
// rtl/apb_wait_fsm.sv - APB setup/access handshake with programmable wait states
// Registers PREADY/PRDATA/PSLVERR and exposes a one-cycle commit pulse.
module apb_wait_fsm
  import dac_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [3:0]  paddr_i,
  input  logic [31:0] pwdata_i,
  input  logic [1:0]  ws_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o,
  output logic        commit_o,
  output logic [3:0]  addr_o,
  output logic        write_o,
  output logic [31:0] wdata_o
);

  apb_st_e     state_q;
  logic [1:0]  wcnt_q;
  logic [3:0]  addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic        pready_q;
  logic [31:0] prdata_q;
  logic        pslverr_q;
  logic        setup;

  assign setup = psel_i & ~penable_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= 2'd0;
      addr_q    <= 4'd0;
      write_q   <= 1'b0;
      wdata_q   <= 32'd0;
      pready_q  <= 1'b0;
      prdata_q  <= 32'd0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= 1'b0;
      prdata_q  <= 32'd0;
      pslverr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (setup) begin
            addr_q  <= paddr_i;
            write_q <= pwrite_i;
            wdata_q <= pwdata_i;
            wcnt_q  <= ws_i;
            if (ws_i == 2'd0) begin
              state_q   <= ST_DONE;
              pready_q  <= 1'b1;
              prdata_q  <= rdata_i;
              pslverr_q <= err_i;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!psel_i) begin
            state_q <= ST_IDLE;
          end else if (penable_i) begin
            if (wcnt_q == 2'd1) begin
              state_q   <= ST_DONE;
              pready_q  <= 1'b1;
              prdata_q  <= rdata_i;
              pslverr_q <= err_i;
            end else begin
              wcnt_q <= wcnt_q - 2'd1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A transfer only takes effect if the requester still holds the access phase.
  assign commit_o  = (state_q == ST_DONE) & psel_i & penable_i;
  assign addr_o    = (state_q == ST_IDLE) ? paddr_i : addr_q;
  assign write_o   = (state_q == ST_IDLE) ? pwrite_i : write_q;
  assign wdata_o   = wdata_q;
  assign pready_o  = pready_q;
  assign prdata_o  = prdata_q;
  assign pslverr_o = pslverr_q;

endmodule

// File: rtl/apb_dac.sv
// rtl/apb_dac.sv - APB3 completer driving a real-valued DAC output after a settling delay
// Holds DATA/CTRL registers, the settle counter and vout.
module apb_dac
  import dac_pkg::*;
#(
  parameter int RES_BITS      = DEF_RES_BITS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output real         vout
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);

  logic                commit;
  logic [3:0]          acc_addr;
  logic                acc_write;
  logic [31:0]         acc_wdata;
  logic                acc_err;
  logic [31:0]         rd_data;

  logic [RES_BITS-1:0] code_q, code_d;
  logic                en_q, en_d;
  logic [1:0]          ws_q, ws_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  real                 vout_q, vout_d;
  logic                busy;
  logic                apply;
  logic                unused_wdata;

  assign busy = (cnt_q != '0);
  assign unused_wdata = ^{acc_wdata[31-RES_BITS:4], acc_wdata[1]};

  always_comb begin
    acc_err = 1'b1;
    rd_data = 32'd0;
    case (acc_addr)
      ADDR_DATA: begin
        acc_err = 1'b0;
        rd_data = {code_q, {(32-RES_BITS){1'b0}}};
      end
      ADDR_CTRL: begin
        acc_err = 1'b0;
        rd_data = {28'd0, ws_q, 1'b0, en_q};
      end
      ADDR_STATUS: begin
        acc_err = acc_write;
        rd_data = {30'd0, en_q, busy};
      end
      default: ;
    endcase
    if (acc_write) rd_data = 32'd0;
  end

  apb_wait_fsm u_fsm (
    .clk_i     (PCLK),
    .rst_i     (PRESET),
    .psel_i    (PSEL),
    .penable_i (PENABLE),
    .pwrite_i  (PWRITE),
    .paddr_i   (PADDR),
    .pwdata_i  (PWDATA),
    .ws_i      (ws_q),
    .rdata_i   (rd_data),
    .err_i     (acc_err),
    .pready_o  (PREADY),
    .prdata_o  (PRDATA),
    .pslverr_o (PSLVERR),
    .commit_o  (commit),
    .addr_o    (acc_addr),
    .write_o   (acc_write),
    .wdata_o   (acc_wdata)
  );

  // A reload or disable in the same cycle as the 1->0 step suppresses that update.
  always_comb begin
    code_d = code_q;
    en_d   = en_q;
    ws_d   = ws_q;
    vout_d = vout_q;
    cnt_d  = busy ? cnt_q - CW'(1) : '0;
    apply  = (cnt_q == CW'(1));
    if (commit && acc_write && !acc_err) begin
      if (acc_addr == ADDR_DATA) begin
        code_d = acc_wdata[31 -: RES_BITS];
        cnt_d  = SETTLE_LOAD;
        apply  = 1'b0;
      end else if (acc_addr == ADDR_CTRL) begin
        en_d = acc_wdata[0];
        ws_d = acc_wdata[3:2];
        if (!acc_wdata[0]) begin
          cnt_d  = '0;
          apply  = 1'b0;
          vout_d = 0.0;
        end else if (!en_q && !busy) begin
          cnt_d = SETTLE_LOAD;
        end
      end
    end
    if (apply) vout_d = en_d ? code2real(32'(code_d), RES_BITS) : 0.0;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      code_q <= '0;
      en_q   <= 1'b0;
      ws_q   <= 2'd0;
      cnt_q  <= '0;
      vout_q <= 0.0;
    end else begin
      code_q <= code_d;
      en_q   <= en_d;
      ws_q   <= ws_d;
      cnt_q  <= cnt_d;
      vout_q <= vout_d;
    end
  end

  assign vout = vout_q;

endmodule

// File: tb/tb_apb_dac.sv
// tb/tb_apb_dac.sv - self-checking bench for apb_dac against a cycle-deadline model
module tb_apb_dac;

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  real         vout;

  apb_dac dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR), .vout(vout)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: register contents plus the posedge index of the last counter load.
  logic [13:0] code_m = '0;
  logic        en_m = 1'b0;
  logic [1:0]  ws_m = '0;
  bit          active_m = 1'b0;
  int          load_m = 0;
  real         exp_vout = 0.0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkr(input string tag, input real obs, input real exp);
    total++;
    assert (obs == exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
    end
  endtask

  function automatic bit busy_at(input int p);
    return active_m && (p > load_m) && (p <= load_m + 4);
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a, input int p);
    case (a)
      4'h0:    return {code_m, 18'd0};
      4'h4:    return {28'd0, ws_m, 1'b0, en_m};
      4'h8:    return {30'd0, en_m, busy_at(p)};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge PCLK);
      #2;
      if (active_m && cyc == load_m + 4)
        exp_vout = en_m ? real'(code_m) / 16384.0 : 0.0;
      chkr("vout_track", vout, exp_vout);
    end
  end

  task automatic xfer(input logic [3:0] a, input logic wr, input logic [31:0] d,
                      output logic [31:0] rd, output logic err, output int waits,
                      output int p, output int c);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = wr; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    waits = 0;
    while (!PREADY && waits < 20) begin
      @(negedge PCLK);
      waits++;
    end
    chk32("pready_seen", PREADY, 1'b1);
    p   = cyc;
    rd  = PRDATA;
    err = PSLVERR;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    c = cyc;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input string tag);
    logic [31:0] rd;
    logic        e;
    int          w, p, c, exp_w;
    bit          was_busy, old_en;
    exp_w = ws_m;
    xfer(a, 1'b1, d, rd, e, w, p, c);
    chk32({tag, "_err"}, e, 1'b0);
    chk32({tag, "_waits"}, w, exp_w);
    chk32({tag, "_prdata"}, rd, 32'd0);
    if (a == 4'h0) begin
      code_m   = d[31:18];
      load_m   = c;
      active_m = 1'b1;
    end else begin
      was_busy = busy_at(c);
      old_en   = en_m;
      en_m     = d[0];
      ws_m     = d[3:2];
      if (!d[0]) begin
        active_m = 1'b0;
        exp_vout = 0.0;
      end else if (!old_en && !was_busy) begin
        load_m   = c;
        active_m = 1'b1;
      end
    end
  endtask

  task automatic do_read(input logic [3:0] a, input string tag, output logic [31:0] rd);
    logic e;
    int   w, p, c, exp_w;
    exp_w = ws_m;
    xfer(a, 1'b0, 32'd0, rd, e, w, p, c);
    chk32({tag, "_err"}, e, 1'b0);
    chk32({tag, "_waits"}, w, exp_w);
    chk32({tag, "_data"}, rd, model_read(a, p));
  endtask

  task automatic do_err(input logic [3:0] a, input logic wr, input string tag);
    logic [31:0] rd;
    logic        e;
    int          w, p, c, exp_w;
    exp_w = ws_m;
    xfer(a, wr, $urandom, rd, e, w, p, c);
    chk32({tag, "_err"}, e, 1'b1);
    chk32({tag, "_waits"}, w, exp_w);
    chk32({tag, "_prdata"}, rd, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK);
    #1;
    code_m = '0; en_m = 1'b0; ws_m = '0; active_m = 1'b0; exp_vout = 0.0;
    @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, d;
    logic [3:0]  a;
    int          op;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    do_reset();
    chk32("rst_pready", PREADY, 1'b0);
    chk32("rst_prdata", PRDATA, 32'd0);
    chk32("rst_pslverr", PSLVERR, 1'b0);
    chkr("rst_vout", vout, 0.0);

    // Reset landing in the middle of a wait-stated read.
    do_write(4'h4, 32'hD, "t1_ctrl");
    do_write(4'h0, 32'h48D0_0000, "t1_data");
    repeat (6) @(negedge PCLK);
    chkr("t1_vout_pre", vout, 4660.0 / 16384.0);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 4'h0; PWRITE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk32("t1_wait_pready", PREADY, 1'b0);
    do_reset();
    chk32("t1_pready", PREADY, 1'b0);
    chkr("t1_vout", vout, 0.0);
    do_read(4'h0, "t1_rd_data", rd);
    chk32("t1_data_zero", rd, 32'd0);
    do_read(4'h4, "t1_rd_ctrl", rd);
    chk32("t1_ctrl_zero", rd, 32'd0);
    do_read(4'h8, "t1_rd_status", rd);
    chk32("t1_status_zero", rd, 32'd0);

    // Zero wait states, half-scale write, settling delay.
    do_write(4'h4, 32'h1, "t2_ctrl");
    repeat (6) @(negedge PCLK);
    do_write(4'h0, 32'h8000_0000, "t2_data");
    do_read(4'h8, "t2_status", rd);
    chk32("t2_busy", rd[0], 1'b1);
    chkr("t2_vout_before", vout, 0.0);
    @(negedge PCLK);
    chkr("t2_vout_after", vout, 0.5);

    do_write(4'h4, 32'hD, "t3_ctrl");
    do_read(4'h0, "t3_rd", rd);
    chk32("t3_value", rd, 32'h8000_0000);

    // Last write wins while still settling.
    do_write(4'h4, 32'h1, "t4_ctrl");
    do_write(4'h0, 32'hFFFF_FFFF, "t4_w1");
    do_write(4'h0, 32'h4000_0000, "t4_w2");
    repeat (6) @(negedge PCLK);
    chkr("t4_vout", vout, 0.25);
    do_read(4'h0, "t4_rd", rd);
    chk32("t4_value", rd, 32'h4000_0000);
    do_write(4'h0, 32'hFFFC_0000, "t4_max");
    repeat (6) @(negedge PCLK);
    chkr("t4_vout_max", vout, 16383.0 / 16384.0);

    do_err(4'hC, 1'b0, "t5_rd_c");
    do_err(4'hC, 1'b1, "t5_wr_c");
    do_err(4'h8, 1'b1, "t5_wr_status");
    do_read(4'h0, "t5_data", rd);
    chk32("t5_data_kept", rd, 32'hFFFC_0000);
    do_read(4'h4, "t5_ctrl", rd);
    chk32("t5_ctrl_kept", rd, 32'h1);

    // Disable forces zero next cycle; re-enable replays the held code.
    do_write(4'h0, 32'h8000_0000, "t6_data");
    repeat (6) @(negedge PCLK);
    chkr("t6_vout_half", vout, 0.5);
    do_write(4'h4, 32'h0, "t6_dis");
    chkr("t6_vout_off", vout, 0.0);
    do_write(4'h4, 32'h1, "t6_en");
    for (int k = 1; k <= 4; k++) begin
      @(negedge PCLK);
      chkr("t6_vout_settle", vout, (k < 4) ? 0.0 : 0.5);
    end

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      repeat ($urandom_range(0, 5)) @(negedge PCLK);
      if (op <= 3) begin
        do_write(4'h0, $urandom, "rnd_wdata");
      end else if (op <= 5) begin
        d = $urandom;
        d[0] = ($urandom_range(0, 3) != 0);
        do_write(4'h4, d, "rnd_wctrl");
      end else if (op <= 8) begin
        a = 4'($urandom_range(0, 2) * 4);
        do_read(a, "rnd_rd", rd);
      end else if ($urandom_range(0, 2) == 0) begin
        do_err(4'h8, 1'b1, "rnd_err_status");
      end else begin
        do a = 4'($urandom_range(0, 15)); while (a == 4'h0 || a == 4'h4 || a == 4'h8);
        do_err(a, 1'($urandom_range(0, 1)), "rnd_err_addr");
      end
    end
    repeat (8) @(negedge PCLK);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
